// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants, types and FSM encoding for the LED frame streamer
// Purpose: pixel width, default geometry/latch constants, FSM state type.
// Ports: none (package).
package led_pkg;

    localparam int PIXEL_WIDTH          = 24;
    localparam int DEFAULT_NUM_LEDS     = 60;
    localparam int DEFAULT_LATCH_CYCLES = 240;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_LATCH   = 2'd3
    } state_e;

endpackage

// File: rtl/led_frame_ram.sv
// rtl/led_frame_ram.sv - two-bank pixel RAM, one write port, one registered read port
// Purpose: holds 2*NUM_LEDS pixels; bank 0 at [0, NUM_LEDS), bank 1 at [NUM_LEDS, 2*NUM_LEDS).
// Ports:
//   clock_i                  clock
//   wr_en_i, wr_bank_i       write strobe and target bank
//   wr_addr_i, wr_data_i     pixel index (>= NUM_LEDS dropped) and pixel value
//   rd_bank_i, rd_addr_i     read bank and pixel index
//   rd_data_o                registered read data, one cycle after address
module led_frame_ram
    import led_pkg::*;
#(
    parameter  int NUM_LEDS = DEFAULT_NUM_LEDS,
    localparam int AW       = $clog2(NUM_LEDS),
    localparam int DEPTH    = 2 * NUM_LEDS,
    localparam int DW       = $clog2(DEPTH)
) (
    input  logic          clock_i,
    input  logic          wr_en_i,
    input  logic          wr_bank_i,
    input  logic [AW-1:0] wr_addr_i,
    input  pixel_t        wr_data_i,
    input  logic          rd_bank_i,
    input  logic [AW-1:0] rd_addr_i,
    output pixel_t        rd_data_o
);

    pixel_t        mem [0:DEPTH-1];
    pixel_t        rd_data_q;
    logic [DW-1:0] wr_phys;
    logic [DW-1:0] rd_phys;
    logic          wr_in_range;

    // Banks are packed back to back so the array is exactly 2*NUM_LEDS deep
    // even when NUM_LEDS is not a power of two.
    assign wr_phys     = DW'(wr_addr_i) + (wr_bank_i ? DW'(NUM_LEDS) : '0);
    assign rd_phys     = DW'(rd_addr_i) + (rd_bank_i ? DW'(NUM_LEDS) : '0);
    assign wr_in_range = int'(wr_addr_i) < NUM_LEDS;

    always_ff @(posedge clock_i) begin
        if (wr_en_i && wr_in_range) begin
            mem[wr_phys] <= wr_data_i;
        end
        rd_data_q <= mem[rd_phys];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/led_frame_streamer.sv
// rtl/led_frame_streamer.sv - double-buffered frame streamer feeding the strip encoder
// Purpose: on frame_start swap banks, stream the front bank over valid/ready, then hold strip_latch.
// Ports:
//   clock, reset                         single clock, synchronous active-high reset
//   write_enable/address/data            host writes, always into the back bank
//   frame_start                          frame tick; dropped (frame_dropped) while busy
//   pixel_data, pixel_valid, pixel_ready stream to the encoder
//   strip_latch                          high during the latch gap
//   busy, frame_done, frame_dropped      status
module led_frame_streamer
    import led_pkg::*;
#(
    parameter  int NUM_LEDS     = DEFAULT_NUM_LEDS,
    parameter  int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    localparam int AW           = $clog2(NUM_LEDS),
    localparam int CW           = $clog2(LATCH_CYCLES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          write_enable,
    input  logic [AW-1:0] write_address,
    input  pixel_t        write_data,
    input  logic          frame_start,
    output pixel_t        pixel_data,
    output logic          pixel_valid,
    input  logic          pixel_ready,
    output logic          strip_latch,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_dropped
);

    localparam logic [AW-1:0] LAST_INDEX = AW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LAST_LATCH = CW'(LATCH_CYCLES - 1);

    state_e        state_q;
    logic [AW-1:0] index_q;
    logic [CW-1:0] latch_cnt_q;
    logic          front_q;
    logic          fetch_phase_q;
    pixel_t        pixel_data_q;
    logic          pixel_valid_q;
    logic          strip_latch_q;
    logic          busy_q;
    logic          frame_done_q;
    logic          frame_dropped_q;
    pixel_t        ram_rdata;

    // Writes always target the bank not being streamed. A write in the swap
    // cycle still uses the pre-swap front bit, so it lands in the bank that
    // becomes front and is read back by the first fetch.
    led_frame_ram #(
        .NUM_LEDS (NUM_LEDS)
    ) u_ram (
        .clock_i   (clock),
        .wr_en_i   (write_enable),
        .wr_bank_i (~front_q),
        .wr_addr_i (write_address),
        .wr_data_i (write_data),
        .rd_bank_i (front_q),
        .rd_addr_i (index_q),
        .rd_data_o (ram_rdata)
    );

    // FETCH is two cycles: phase 0 presents the address and the RAM registers
    // the word; phase 1 copies it into the output register and raises valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            index_q         <= '0;
            latch_cnt_q     <= '0;
            front_q         <= 1'b0;
            fetch_phase_q   <= 1'b0;
            pixel_data_q    <= '0;
            pixel_valid_q   <= 1'b0;
            strip_latch_q   <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            frame_done_q    <= 1'b0;
            frame_dropped_q <= frame_start && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        front_q       <= ~front_q;
                        index_q       <= '0;
                        fetch_phase_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!fetch_phase_q) begin
                        fetch_phase_q <= 1'b1;
                    end else begin
                        fetch_phase_q <= 1'b0;
                        pixel_data_q  <= ram_rdata;
                        pixel_valid_q <= 1'b1;
                        state_q       <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (pixel_valid_q && pixel_ready) begin
                        pixel_valid_q <= 1'b0;
                        if (index_q == LAST_INDEX) begin
                            latch_cnt_q   <= '0;
                            strip_latch_q <= 1'b1;
                            state_q       <= ST_LATCH;
                        end else begin
                            index_q <= index_q + 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt_q == LAST_LATCH) begin
                        strip_latch_q <= 1'b0;
                        frame_done_q  <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        latch_cnt_q <= latch_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pixel_data    = pixel_data_q;
    assign pixel_valid   = pixel_valid_q;
    assign strip_latch   = strip_latch_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_led_frame_streamer.sv
// tb/tb_led_frame_streamer.sv - randomized self-checking bench for led_frame_streamer
module tb_led_frame_streamer;

    localparam int N    = 60;
    localparam int LAT  = 240;
    localparam int AW   = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [23:0]   write_data;
    logic          frame_start;
    logic [23:0]   pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          strip_latch;
    logic          busy;
    logic          frame_done;
    logic          frame_dropped;

    int checks = 0;
    int errors = 0;

    // Reference: two frame images and which one is in front.
    logic [23:0] bank_img [2][N];
    int          m_front;

    // Monitor-owned event history.
    logic [23:0] rx [$];
    int          hs_count     = 0;
    int          latch_cycles = 0;
    int          done_cnt     = 0;
    int          drop_cnt     = 0;
    logic        prev_valid   = 1'b0;
    logic        prev_hs      = 1'b0;
    logic [23:0] prev_data    = '0;

    led_frame_streamer dut (
        .clock         (clock),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .frame_start   (frame_start),
        .pixel_data    (pixel_data),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .strip_latch   (strip_latch),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_dropped (frame_dropped)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sampled mid-cycle: inputs change just after posedge, outputs are settled.
    always @(negedge clock) begin
        if (!reset) begin
            if (pixel_valid && prev_valid && !prev_hs)
                check("hold", {8'h0, pixel_data}, {8'h0, prev_data});
            if (pixel_valid && pixel_ready) begin
                rx.push_back(pixel_data);
                hs_count++;
            end
            if (strip_latch)   latch_cycles++;
            if (frame_done)    done_cnt++;
            if (frame_dropped) drop_cnt++;
        end
        prev_valid = pixel_valid;
        prev_hs    = pixel_valid && pixel_ready;
        prev_data  = pixel_data;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_write(input int addr, input logic [23:0] data);
        if (addr < N) bank_img[1 - m_front][addr] = data;
    endtask

    task automatic write_pix(input int addr, input logic [23:0] data);
        write_enable  = 1'b1;
        write_address = AW'(addr);
        write_data    = data;
        tick();
        write_enable  = 1'b0;
        model_write(addr, data);
    endtask

    // gap: 0 = always ready, -1 = random ready, >0 = ready held low for gap valid cycles per pixel.
    task automatic run_frame(input int gap, input bit rewrite, input bit drops,
                             input bit do_reset, input bit swap_write);
        logic [23:0] exp [N];
        int  hs0, lc0, dc0, dr0, rx0;
        int  wait_cnt, wr_idx, latch_seen, h, exp_drops;
        bit  finished, d1, d2, d3;
        logic [23:0] sw_data;
        hs0 = hs_count; lc0 = latch_cycles; dc0 = done_cnt; dr0 = drop_cnt; rx0 = rx.size();
        wait_cnt = 0; wr_idx = 0; latch_seen = 0; finished = 0; d1 = 0; d2 = 0; d3 = 0;
        exp_drops = drops ? 3 : 0;
        sw_data = 24'($urandom);

        frame_start = 1'b1;
        pixel_ready = (gap == 0);
        if (swap_write) begin
            write_enable  = 1'b1;
            write_address = AW'(7);
            write_data    = sw_data;
        end
        tick();
        frame_start  = 1'b0;
        write_enable = 1'b0;
        if (swap_write) model_write(7, sw_data);
        m_front = 1 - m_front;
        for (int i = 0; i < N; i++) exp[i] = bank_img[m_front][i];

        check("lat0", {31'h0, pixel_valid}, 32'h0);
        check("busy", {31'h0, busy}, 32'h1);
        tick();
        check("lat1", {31'h0, pixel_valid}, 32'h0);
        tick();
        check("lat2", {31'h0, pixel_valid}, 32'h1);

        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            frame_start  = 1'b0;
            write_enable = 1'b0;
            if (strip_latch) latch_seen++;
            if (gap < 0)       pixel_ready = 1'($urandom_range(0, 1));
            else if (gap == 0) pixel_ready = 1'b1;
            else               pixel_ready = (wait_cnt >= gap);

            if (rewrite && (hs_count - hs0) >= 20 && wr_idx < N) begin
                write_enable  = 1'b1;
                write_address = AW'(wr_idx);
                write_data    = 24'hFFFFFF;
                model_write(wr_idx, 24'hFFFFFF);
                wr_idx++;
            end
            if (drops) begin
                if (!d1 && (hs_count - hs0) == 10 && pixel_valid) begin
                    frame_start = 1'b1; d1 = 1;
                end else if (!d2 && strip_latch && latch_seen == 100) begin
                    frame_start = 1'b1; d2 = 1;
                end else if (!d3 && strip_latch && latch_seen == LAT) begin
                    frame_start = 1'b1; d3 = 1;
                end
            end
            if (do_reset && (hs_count - hs0) == 30) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                write_enable = 1'b0;
                check("rst_valid", {31'h0, pixel_valid}, 32'h0);
                check("rst_latch", {31'h0, strip_latch}, 32'h0);
                check("rst_busy",  {31'h0, busy},        32'h0);
                check("rst_data",  {8'h0, pixel_data},   32'h0);
                m_front = 0;
                tick();
                return;
            end

            h = hs_count;
            tick();
            if (hs_count != h)   wait_cnt = 0;
            else if (pixel_valid) wait_cnt++;
            if (frame_done) finished = 1;
        end
        frame_start  = 1'b0;
        write_enable = 1'b0;
        tick();

        check("timeout", {31'h0, finished}, 32'h1);
        check("count", rx.size() - rx0, N);
        for (int i = 0; i < N && rx0 + i < rx.size(); i++)
            check($sformatf("px%0d", i), {8'h0, rx[rx0 + i]}, {8'h0, exp[i]});
        check("latch_len", latch_cycles - lc0, LAT);
        check("done_cnt",  done_cnt - dc0, 1);
        check("drop_cnt",  drop_cnt - dr0, exp_drops);
        check("idle_busy", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        write_enable  = 1'b0;
        write_address = '0;
        write_data    = '0;
        frame_start   = 1'b0;
        pixel_ready   = 1'b0;
        m_front       = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) bank_img[b][i] = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("r_valid", {31'h0, pixel_valid},   32'h0);
        check("r_data",  {8'h0, pixel_data},     32'h0);
        check("r_latch", {31'h0, strip_latch},   32'h0);
        check("r_busy",  {31'h0, busy},          32'h0);
        check("r_done",  {31'h0, frame_done},    32'h0);
        check("r_drop",  {31'h0, frame_dropped}, 32'h0);

        // Uniform frame, encoder always ready.
        for (int i = 0; i < N; i++) write_pix(i, 24'h800080);
        run_frame(0, 0, 0, 0, 0);

        // Heavy back-pressure.
        for (int i = 0; i < N; i++) write_pix(i, 24'($urandom));
        run_frame(50, 0, 0, 0, 0);

        // Double buffer: index pattern streamed while back is overwritten.
        for (int i = 0; i < N; i++) write_pix(i, 24'(i));
        run_frame(-1, 1, 0, 0, 0);
        run_frame(-1, 0, 0, 0, 0);

        // Dropped frame ticks in PRESENT, mid-LATCH and on the last latch cycle.
        for (int i = 0; i < N; i++) write_pix(i, 24'($urandom));
        run_frame(-1, 0, 1, 0, 0);
        run_frame(-1, 0, 0, 0, 0);

        // Reset mid-frame, then restart.
        for (int i = 0; i < N; i++) write_pix(i, 24'($urandom));
        run_frame(-1, 0, 0, 1, 0);
        run_frame(-1, 0, 0, 0, 0);

        // Out-of-range writes, and a write coincident with the swap.
        for (int i = 0; i < N; i++) write_pix(i, 24'($urandom));
        write_pix(60, 24'hABCDEF);
        write_pix(63, 24'h123456);
        run_frame(-1, 0, 0, 0, 1);
        run_frame(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
